cta_scheduler: RTL
==================

Name: cta_scheduler

Overview:
- Parametrised CTA dispatcher for one SM. Walks a 3-D grid of CTA indices in x-major order and binds each CTA to a free, enabled hardware slot.
- Keeps per-slot CTA ids for the functional units and retires slots on exit.
- Signals kernel completion only after every CTA has been dispatched and has also exited.
- Sits between kernel-launch logic and the warp scheduler/FU ctaid read path.

Parameters:
- NUM_SLOTS, 8, number of CTA slots (power of two, 2..64).
- SLOT_LOG, 3, log2(NUM_SLOTS).
- ID_W, 16, width of each ctaid / nctaid dimension.
- CNT_W, 32, width of the dispatched and retired CTA counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- launch_i  in  1  one-cycle kernel start; latches grid dims.
- nctaid_x_i  in  ID_W  grid size x, sampled on launch_i.
- nctaid_y_i  in  ID_W  grid size y, sampled on launch_i.
- nctaid_z_i  in  ID_W  grid size z, sampled on launch_i.
- slotEnMask_i  in  NUM_SLOTS  slots allowed to receive CTAs (level, may change anytime).
- stall_i  in  1  freezes dispatch only.
- exit_valid_i  in  1  a CTA has exited.
- exit_slot_i  in  SLOT_LOG  slot of the exiting CTA.
- query_slot_i  in  SLOT_LOG  slot whose ctaid is read.
- ctaid_x_o  out  ID_W  combinational ctaid x of query_slot_i.
- ctaid_y_o  out  ID_W  combinational ctaid y of query_slot_i.
- ctaid_z_o  out  ID_W  combinational ctaid z of query_slot_i.
- slotRunMask_o  out  NUM_SLOTS  registered running-slot bitmap.
- dispatch_valid_o  out  1  registered pulse: a CTA was bound this cycle.
- dispatch_slot_o  out  SLOT_LOG  slot bound by that dispatch.
- busy_o  out  1  high in DISPATCH or DRAIN.
- kernelDone_o  out  1  high in DONE.
- dispatched_o  out  CNT_W  CTAs dispatched since launch.
- retired_o  out  CNT_W  CTAs retired since launch.
- exitErr_o  out  1  sticky: exit seen on a non-running slot.

Behaviour:
- Reset: FSM to IDLE. All outputs 0. Run mask 0. Pointers, counters and latched dims 0. Slot id RAM contents don't-care. Reset mid-kernel abandons the kernel with no done pulse.
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE/DONE + launch_i:
  - Latch dims; clear pointers, counters, exitErr_o and kernelDone_o.
  - If any dim == 0, go to DONE (kernelDone_o=1 on the next cycle). Otherwise go to DISPATCH.
- launch_i in DISPATCH or DRAIN is ignored.
- Free set = ~slotRunMask & slotEnMask_i, taken from the registered run mask. A slot freed by an exit in cycle N is first re-dispatchable in cycle N+1.
- DISPATCH, each cycle with ~stall_i and a non-empty free set:
  - Pick the lowest-index free slot s.
  - Write the pointer (px,py,pz) to slot s and set run[s].
  - dispatch_valid_o=1, dispatch_slot_o=s on the next cycle. dispatched_o increments.
  - Throughput is one CTA per cycle.
- Pointer advance (x-major):
  - px+1 while px < nx-1, otherwise px=0 and carry into y.
  - Same rule y to z.
  - When z wraps, the last CTA has been issued and the FSM goes to DRAIN.
  - Compares are unsigned at ID_W. nx-1 is computed at ID_W, with no underflow because dims are ≠ 0.
- stall_i or an empty free set: no dispatch, dispatch_valid_o=0, pointer holds.
- Exit:
  - exit_valid_i with run[exit_slot_i]=1 clears the bit next cycle and increments retired_o. Processed in every state and during stall.
  - Exit on a non-running slot: no state change, exitErr_o set.
  - Exit and dispatch on different slots in the same cycle: both take effect. Same slot is impossible per the free-set rule.
- DRAIN: when the run mask is all 0 (after update), go to DONE. kernelDone_o rises one cycle after the last exit is registered.
- DONE holds until launch_i or reset.
- slotEnMask_i dropping a running slot does not stop that CTA. It only blocks new dispatch to the slot.
- Counters wrap at 2^CNT_W; no saturation.

Test Plan:
- Grid 3x2x1, all 8 slots enabled, no exits → dispatch pulses on slots 0..5 in consecutive cycles with ids (0,0,0),(1,0,0),(2,0,0),(0,1,0),(1,1,0),(2,1,0); FSM in DRAIN; dispatched_o=6; slotRunMask_o=8'h3F.
- Grid 10x1x1 with slotEnMask_i=8'h0F → 4 dispatches then stall. Exit slot 2 at cycle N → slot 2 redispatched at N+1 with x=4. After all 10 exits, kernelDone_o=1 and retired_o=10.
- stall_i held 5 cycles mid-dispatch while an exit arrives → no dispatch pulses, exit registered, pointer unchanged. Dispatch resumes on deassert.
- Launch with nctaid_y_i=0 → DONE next cycle, zero dispatches, kernelDone_o=1.
- Exit on a non-running slot 7 → exitErr_o=1, run mask unchanged. A relaunch clears exitErr_o. launch_i during DISPATCH is ignored.
- Reset asserted in DRAIN with 3 slots running → next cycle all outputs 0, FSM IDLE. A fresh launch restarts ids at (0,0,0).

Source files
------------

// File: rtl/cta_scheduler.sv
// CTA dispatcher for one SM: walks a 3-D grid in x-major order, binds each CTA to the
// lowest free enabled slot, keeps per-slot ctaids and reports completion once all CTAs exit.
module cta_scheduler #(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_LOG  = 3,
    parameter int ID_W      = 16,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 launch_i,
    input  logic [ID_W-1:0]      nctaid_x_i,
    input  logic [ID_W-1:0]      nctaid_y_i,
    input  logic [ID_W-1:0]      nctaid_z_i,
    input  logic [NUM_SLOTS-1:0] slotEnMask_i,
    input  logic                 stall_i,
    input  logic                 exit_valid_i,
    input  logic [SLOT_LOG-1:0]  exit_slot_i,
    input  logic [SLOT_LOG-1:0]  query_slot_i,
    output logic [ID_W-1:0]      ctaid_x_o,
    output logic [ID_W-1:0]      ctaid_y_o,
    output logic [ID_W-1:0]      ctaid_z_o,
    output logic [NUM_SLOTS-1:0] slotRunMask_o,
    output logic                 dispatch_valid_o,
    output logic [SLOT_LOG-1:0]  dispatch_slot_o,
    output logic                 busy_o,
    output logic                 kernelDone_o,
    output logic [CNT_W-1:0]     dispatched_o,
    output logic [CNT_W-1:0]     retired_o,
    output logic                 exitErr_o,
    output logic [1:0]           fsm_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        nx_q, nx_d, ny_q, ny_d, nz_q, nz_d;
    logic [ID_W-1:0]        px_q, px_d, py_q, py_d, pz_q, pz_d;
    logic [NUM_SLOTS-1:0]   run_q, run_d;
    logic                   dv_q, dv_d;
    logic [SLOT_LOG-1:0]    dslot_q, dslot_d;
    logic [CNT_W-1:0]       disp_q, disp_d, ret_q, ret_d;
    logic                   err_q, err_d;
    logic [ID_W-1:0]        idx_q [NUM_SLOTS];
    logic [ID_W-1:0]        idx_d [NUM_SLOTS];
    logic [ID_W-1:0]        idy_q [NUM_SLOTS];
    logic [ID_W-1:0]        idy_d [NUM_SLOTS];
    logic [ID_W-1:0]        idz_q [NUM_SLOTS];
    logic [ID_W-1:0]        idz_d [NUM_SLOTS];

    logic [NUM_SLOTS-1:0]   free_mask;
    logic                   free_any;
    logic [SLOT_LOG-1:0]    free_slot;
    logic                   do_dispatch;
    logic [ID_W-1:0]        nx_m1, ny_m1, nz_m1;

    // Dims are never zero while dispatching, so these cannot underflow when used.
    assign nx_m1 = nx_q - ID_W'(1);
    assign ny_m1 = ny_q - ID_W'(1);
    assign nz_m1 = nz_q - ID_W'(1);

    // Free set comes from the registered run mask, so a slot freed this cycle waits one cycle.
    always_comb begin
        free_mask = ~run_q & slotEnMask_i;
        free_any  = |free_mask;
        free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_mask[i]) free_slot = SLOT_LOG'(i);
        end
    end

    assign do_dispatch = (state_q == ST_DISPATCH) && !stall_i && free_any;

    always_comb begin
        state_d = state_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        nz_d    = nz_q;
        px_d    = px_q;
        py_d    = py_q;
        pz_d    = pz_q;
        run_d   = run_q;
        dv_d    = 1'b0;
        dslot_d = dslot_q;
        disp_d  = disp_q;
        ret_d   = ret_q;
        err_d   = err_q;
        idx_d   = idx_q;
        idy_d   = idy_q;
        idz_d   = idz_q;

        if (exit_valid_i) begin
            if (run_q[exit_slot_i]) begin
                run_d[exit_slot_i] = 1'b0;
                ret_d = ret_q + CNT_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end

        if (do_dispatch) begin
            run_d[free_slot] = 1'b1;
            idx_d[free_slot] = px_q;
            idy_d[free_slot] = py_q;
            idz_d[free_slot] = pz_q;
            dv_d    = 1'b1;
            dslot_d = free_slot;
            disp_d  = disp_q + CNT_W'(1);
            // x-major walk; a carry out of z means the last CTA was just issued.
            if (px_q < nx_m1) begin
                px_d = px_q + ID_W'(1);
            end else begin
                px_d = '0;
                if (py_q < ny_m1) begin
                    py_d = py_q + ID_W'(1);
                end else begin
                    py_d = '0;
                    if (pz_q < nz_m1) begin
                        pz_d = pz_q + ID_W'(1);
                    end else begin
                        pz_d    = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch_i) begin
                    nx_d   = nctaid_x_i;
                    ny_d   = nctaid_y_i;
                    nz_d   = nctaid_z_i;
                    px_d   = '0;
                    py_d   = '0;
                    pz_d   = '0;
                    disp_d = '0;
                    ret_d  = '0;
                    err_d  = 1'b0;
                    if ((nctaid_x_i == '0) || (nctaid_y_i == '0) || (nctaid_z_i == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DISPATCH;
                    end
                end
            end
            ST_DRAIN: begin
                if (run_d == '0) state_d = ST_DONE;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            nx_q    <= '0;
            ny_q    <= '0;
            nz_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            pz_q    <= '0;
            run_q   <= '0;
            dv_q    <= 1'b0;
            dslot_q <= '0;
            disp_q  <= '0;
            ret_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                idx_q[i] <= '0;
                idy_q[i] <= '0;
                idz_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            nz_q    <= nz_d;
            px_q    <= px_d;
            py_q    <= py_d;
            pz_q    <= pz_d;
            run_q   <= run_d;
            dv_q    <= dv_d;
            dslot_q <= dslot_d;
            disp_q  <= disp_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            idy_q   <= idy_d;
            idz_q   <= idz_d;
        end
    end

    assign ctaid_x_o        = idx_q[query_slot_i];
    assign ctaid_y_o        = idy_q[query_slot_i];
    assign ctaid_z_o        = idz_q[query_slot_i];
    assign slotRunMask_o    = run_q;
    assign dispatch_valid_o = dv_q;
    assign dispatch_slot_o  = dslot_q;
    assign busy_o           = (state_q == ST_DISPATCH) || (state_q == ST_DRAIN);
    assign kernelDone_o     = (state_q == ST_DONE);
    assign dispatched_o     = disp_q;
    assign retired_o        = ret_q;
    assign exitErr_o        = err_q;
    assign fsm_state_o      = state_q;

endmodule
